// File: rtl/periph_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_bridge_pkg
// Shared definitions for the CPU-to-peripheral bus bridge: FSM state
// encodings, peripheral slot IDs, the default address window and a small
// helper used by the bridge output logic.
// -----------------------------------------------------------------------------
package periph_bus_bridge_pkg;

  // Default value of cpu_addr[31:12] that selects the peripheral window.
  localparam logic [19:0] BASE_HI_DEFAULT = 20'hBFD00;

  // Fixed slot assignment on the peripheral bus.
  localparam logic [3:0] SLOT_GPIO  = 4'd0;
  localparam logic [3:0] SLOT_UART  = 4'd1;
  localparam logic [3:0] SLOT_TIMER = 4'd2;
  localparam logic [3:0] SLOT_SPARE = 4'd3;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // True for the states in which the CPU sees its completion pulse.
  function automatic logic is_ack_state(input state_e st);
    return ((st == ST_DONE) || (st == ST_ERR)) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/periph_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// periph_bus_bridge_if
// Bundles the CPU request port and the peripheral bus of the bridge.
//   slave  : the bridge's view (takes CPU requests and slot read data,
//            drives ack/err/rdata and the peripheral address/data/strobes).
//   master : the surrounding system's view (CPU plus peripherals).
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  request from the CPU
//   cpu_ack/cpu_err/cpu_rdata          completion back to the CPU
//   bus_address/bus_data_o             shared address / write data
//   bus_read/bus_write                 per-slot one-cycle strobes
//   bus_data_i                         slot k read data on [32k+31:32k]
// -----------------------------------------------------------------------------
interface periph_bus_bridge_if #(
  parameter int NSLOT = 4
);

  logic                   cpu_req;
  logic                   cpu_we;
  logic [31:0]            cpu_addr;
  logic [31:0]            cpu_wdata;
  logic                   cpu_ack;
  logic                   cpu_err;
  logic [31:0]            cpu_rdata;
  logic [7:0]             bus_address;
  logic [31:0]            bus_data_o;
  logic [NSLOT-1:0]       bus_read;
  logic [NSLOT-1:0]       bus_write;
  logic [32*NSLOT-1:0]    bus_data_i;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_data_i,
    output cpu_ack, cpu_err, cpu_rdata,
    output bus_address, bus_data_o, bus_read, bus_write
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_data_i,
    input  cpu_ack, cpu_err, cpu_rdata,
    input  bus_address, bus_data_o, bus_read, bus_write
  );

endinterface

// File: rtl/periph_addr_decode.sv
// -----------------------------------------------------------------------------
// periph_addr_decode
// Combinational decode of a CPU address into a peripheral slot.
// Ports:
//   cpu_addr [31:8]  upper address bits (the low byte never affects decode)
//   hit              1 when the address lies in the window and slot < NSLOT
//   slot             slot index, cpu_addr[11:8]
// -----------------------------------------------------------------------------
module periph_addr_decode
  import periph_bus_bridge_pkg::*;
#(
  parameter int          NSLOT   = 4,
  parameter logic [19:0] BASE_HI = BASE_HI_DEFAULT
) (
  input  logic [31:8] cpu_addr,
  output logic        hit,
  output logic [3:0]  slot
);

  // Window compare and slot range check; widened to 5 bits so NSLOT=16 fits.
  always_comb begin
    slot = cpu_addr[11:8];
    if ((cpu_addr[31:12] == BASE_HI) && ({1'b0, cpu_addr[11:8]} < 5'(NSLOT))) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/periph_bus_bridge.sv
// -----------------------------------------------------------------------------
// periph_bus_bridge
// Single-master bridge from the CPU data port to the peripheral bus.
// A request is decoded into one slot; the bridge drives address and data for
// one setup cycle, pulses that slot's read or write strobe for one cycle,
// optionally waits RECOVERY idle cycles, then acknowledges. Unmapped
// addresses are acknowledged with cpu_err one cycle after the request and
// never reach the bus.
// Ports:
//   clk_bus  bus clock, all state on its rising edge
//   rst      synchronous active-high reset
//   bus      periph_bus_bridge_if.slave (CPU port + peripheral bus)
// Parameters: NSLOT (1..16), BASE_HI, RECOVERY (0..15).
// -----------------------------------------------------------------------------
module periph_bus_bridge
  import periph_bus_bridge_pkg::*;
#(
  parameter int          NSLOT    = 4,
  parameter logic [19:0] BASE_HI  = BASE_HI_DEFAULT,
  parameter int          RECOVERY = 1
) (
  input  logic               clk_bus,
  input  logic               rst,
  periph_bus_bridge_if.slave bus
);

  localparam logic       HAS_RECOVERY  = (RECOVERY > 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] RECOVERY_LOAD = (RECOVERY > 0) ? 4'(RECOVERY - 1) : 4'd0;

  state_e             state_r;
  state_e             next_state_s;
  logic               accept_s;
  logic               hit_s;
  logic [3:0]         slot_dec_s;

  logic               we_r;
  logic               we_d_s;
  logic [3:0]         slot_r;
  logic [3:0]         slot_d_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_d_s;

  logic [NSLOT-1:0]   slot_vec_s;
  logic [31:0]        rd_mux_s;

  logic               cpu_ack_r;
  logic               cpu_ack_d_s;
  logic               cpu_err_r;
  logic               cpu_err_d_s;
  logic [31:0]        cpu_rdata_r;
  logic [31:0]        cpu_rdata_d_s;
  logic [7:0]         bus_address_r;
  logic [7:0]         bus_address_d_s;
  logic [31:0]        bus_data_o_r;
  logic [31:0]        bus_data_o_d_s;
  logic [NSLOT-1:0]   bus_read_r;
  logic [NSLOT-1:0]   bus_read_d_s;
  logic [NSLOT-1:0]   bus_write_r;
  logic [NSLOT-1:0]   bus_write_d_s;

  periph_addr_decode #(
    .NSLOT   (NSLOT),
    .BASE_HI (BASE_HI)
  ) u_decode (
    .cpu_addr (bus.cpu_addr[31:8]),
    .hit      (hit_s),
    .slot     (slot_dec_s)
  );

  // One-hot slot select and read-data mux for the latched slot.
  always_comb begin
    rd_mux_s = 32'd0;
    for (int k = 0; k < NSLOT; k++) begin
      slot_vec_s[k] = (slot_r == 4'(k)) ? 1'b1 : 1'b0;
      if (slot_r == 4'(k)) begin
        rd_mux_s = bus.bus_data_i[32*k +: 32];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          if (hit_s) begin
            next_state_s = ST_SETUP;
          end else begin
            next_state_s = ST_ERR;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:  next_state_s = ST_STROBE;
      ST_STROBE: begin
        if (HAS_RECOVERY) begin
          next_state_s = ST_RECOVER;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_RECOVER: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RECOVER;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      ST_ERR:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of every registered output and the
  // per-transaction latches. Strobes and ack are decoded from the state being
  // entered so they appear registered in the cycle that state occupies.
  always_comb begin
    accept_s = ((state_r == ST_IDLE) && bus.cpu_req) ? 1'b1 : 1'b0;

    cpu_ack_d_s = is_ack_state(next_state_s);
    cpu_err_d_s = (next_state_s == ST_ERR) ? 1'b1 : 1'b0;

    if ((next_state_s == ST_STROBE) && we_r) begin
      bus_write_d_s = slot_vec_s;
    end else begin
      bus_write_d_s = {NSLOT{1'b0}};
    end

    if ((next_state_s == ST_STROBE) && !we_r) begin
      bus_read_d_s = slot_vec_s;
    end else begin
      bus_read_d_s = {NSLOT{1'b0}};
    end

    // Read data is captured at the edge that closes the strobe cycle.
    if ((state_r == ST_STROBE) && !we_r) begin
      cpu_rdata_d_s = rd_mux_s;
    end else if (next_state_s == ST_ERR) begin
      cpu_rdata_d_s = 32'd0;
    end else begin
      cpu_rdata_d_s = cpu_rdata_r;
    end

    // Address and data only move for mapped accesses, so a miss leaves the
    // peripheral bus untouched.
    if (accept_s && hit_s) begin
      bus_address_d_s = bus.cpu_addr[7:0];
      bus_data_o_d_s  = bus.cpu_wdata;
    end else begin
      bus_address_d_s = bus_address_r;
      bus_data_o_d_s  = bus_data_o_r;
    end

    if (accept_s) begin
      we_d_s   = bus.cpu_we;
      slot_d_s = slot_dec_s;
    end else begin
      we_d_s   = we_r;
      slot_d_s = slot_r;
    end

    case (state_r)
      ST_STROBE: cnt_d_s = RECOVERY_LOAD;
      ST_RECOVER: begin
        if (cnt_r != 4'd0) begin
          cnt_d_s = cnt_r - 4'd1;
        end else begin
          cnt_d_s = cnt_r;
        end
      end
      default: cnt_d_s = cnt_r;
    endcase
  end

  // Output and transaction registers.
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      we_r          <= 1'b0;
      slot_r        <= 4'd0;
      cnt_r         <= 4'd0;
      cpu_ack_r     <= 1'b0;
      cpu_err_r     <= 1'b0;
      cpu_rdata_r   <= 32'd0;
      bus_address_r <= 8'd0;
      bus_data_o_r  <= 32'd0;
      bus_read_r    <= {NSLOT{1'b0}};
      bus_write_r   <= {NSLOT{1'b0}};
    end else begin
      we_r          <= we_d_s;
      slot_r        <= slot_d_s;
      cnt_r         <= cnt_d_s;
      cpu_ack_r     <= cpu_ack_d_s;
      cpu_err_r     <= cpu_err_d_s;
      cpu_rdata_r   <= cpu_rdata_d_s;
      bus_address_r <= bus_address_d_s;
      bus_data_o_r  <= bus_data_o_d_s;
      bus_read_r    <= bus_read_d_s;
      bus_write_r   <= bus_write_d_s;
    end
  end

  assign bus.cpu_ack     = cpu_ack_r;
  assign bus.cpu_err     = cpu_err_r;
  assign bus.cpu_rdata   = cpu_rdata_r;
  assign bus.bus_address = bus_address_r;
  assign bus.bus_data_o  = bus_data_o_r;
  assign bus.bus_read    = bus_read_r;
  assign bus.bus_write   = bus_write_r;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_bridge
// Self-checking bench: a directed vector table and randomized accesses on a
// RECOVERY=1 bridge, plus hand-written sequences for reset mid-transaction,
// back-to-back requests (RECOVERY=0) and a long recovery (RECOVERY=3).
// -----------------------------------------------------------------------------
module tb_periph_bus_bridge;
  import periph_bus_bridge_pkg::*;

  logic clk_bus = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_rd;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wr;
    logic [3:0]  exp_rdv;
  } vec_t;

  vec_t tv[10];

  always #5 clk_bus = ~clk_bus;

  periph_bus_bridge_if #(.NSLOT(4)) bif1 ();
  periph_bus_bridge_if #(.NSLOT(4)) bif0 ();
  periph_bus_bridge_if #(.NSLOT(4)) bif3 ();

  periph_bus_bridge #(.NSLOT(4), .BASE_HI(20'hBFD00), .RECOVERY(1)) dut1 (
    .clk_bus (clk_bus), .rst (rst), .bus (bif1));
  periph_bus_bridge #(.NSLOT(4), .BASE_HI(20'hBFD00), .RECOVERY(0)) dut0 (
    .clk_bus (clk_bus), .rst (rst), .bus (bif0));
  periph_bus_bridge #(.NSLOT(4), .BASE_HI(20'hBFD00), .RECOVERY(3)) dut3 (
    .clk_bus (clk_bus), .rst (rst), .bus (bif3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference address rule: window match and slot below the slot count.
  function automatic bit ref_hit(input logic [31:0] a);
    return (a[31:12] == 20'hBFD00) && (a[11:8] < 4'd4);
  endfunction

  // One access on dut1, compared against the supplied expectations.
  task automatic run1(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [127:0] sbus,
                      input logic exp_err, input int exp_lat, input logic [31:0] exp_rd,
                      input logic [3:0] exp_wr, input logic [3:0] exp_rdv);
    int cyc;
    int lat;
    int nstb;
    logic [3:0] stb_w;
    logic [3:0] stb_r;
    logic [7:0] a_at;
    logic [31:0] d_at;
    logic got_ack;
    logic got_err;
    logic [31:0] got_rd;
    @(posedge clk_bus); #1;
    bif1.bus_data_i = sbus;
    bif1.cpu_req = 1'b1;
    bif1.cpu_we = we;
    bif1.cpu_addr = addr;
    bif1.cpu_wdata = wdata;
    cyc = 0; lat = -1; nstb = 0; stb_w = 4'd0; stb_r = 4'd0;
    a_at = 8'd0; d_at = 32'd0; got_ack = 1'b0; got_err = 1'b0; got_rd = 32'd0;
    while (!got_ack && cyc < 30) begin
      @(negedge clk_bus);
      cyc++;
      if (bif1.bus_write != 4'd0 || bif1.bus_read != 4'd0) begin
        nstb++;
        stb_w |= bif1.bus_write;
        stb_r |= bif1.bus_read;
        a_at = bif1.bus_address;
        d_at = bif1.bus_data_o;
      end
      if (bif1.cpu_ack) begin
        got_ack = 1'b1;
        got_err = bif1.cpu_err;
        got_rd = bif1.cpu_rdata;
        lat = cyc - 1;
      end
    end
    @(posedge clk_bus); #1;
    bif1.cpu_req = 1'b0;
    @(negedge clk_bus);
    chk({tag, ".ack_one_cycle"}, 32'(bif1.cpu_ack), 32'd0);
    chk({tag, ".ack_seen"}, 32'(got_ack), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(got_err), 32'(exp_err));
    chk({tag, ".rdata"}, got_rd, exp_rd);
    chk({tag, ".strobe_cycles"}, 32'(nstb), ((exp_wr | exp_rdv) != 4'd0) ? 32'd1 : 32'd0);
    chk({tag, ".bus_write"}, 32'(stb_w), 32'(exp_wr));
    chk({tag, ".bus_read"}, 32'(stb_r), 32'(exp_rdv));
    if ((exp_wr | exp_rdv) != 4'd0) chk({tag, ".bus_address"}, 32'(a_at), 32'(addr[7:0]));
    if (exp_wr != 4'd0) chk({tag, ".bus_data_o"}, d_at, wdata);
    model_rd = exp_rd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] sbus;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int kind;
    int slot;
    logic [31:0] exp_rd;
    logic [3:0] exp_wr;
    logic [3:0] exp_rdv;
    int cyc;
    int nstb;
    int nack;
    int s_cyc[3];
    int a_cyc[3];
    logic [31:0] rd_seen;
    logic wr_seen;
    logic ack_seen;

    tv[0] = '{we:1'b1, addr:32'hBFD0_0004, wdata:32'hA5A5_0001, sdata:32'h0,
              exp_err:1'b0, exp_lat:4, exp_rdata:32'h0, exp_wr:4'b0001, exp_rdv:4'b0000};
    tv[1] = '{we:1'b0, addr:32'hBFD0_0100, wdata:32'h0, sdata:32'h1234_5678,
              exp_err:1'b0, exp_lat:4, exp_rdata:32'h1234_5678, exp_wr:4'b0000, exp_rdv:4'b0010};
    tv[2] = '{we:1'b0, addr:32'hBFD0_0500, wdata:32'h0, sdata:32'h0,
              exp_err:1'b1, exp_lat:1, exp_rdata:32'h0, exp_wr:4'b0000, exp_rdv:4'b0000};
    tv[3] = '{we:1'b0, addr:32'h8000_0000, wdata:32'h0, sdata:32'h0,
              exp_err:1'b1, exp_lat:1, exp_rdata:32'h0, exp_wr:4'b0000, exp_rdv:4'b0000};
    tv[4] = '{we:1'b0, addr:32'hBFD0_0208, wdata:32'h0, sdata:32'hCAFE_F00D,
              exp_err:1'b0, exp_lat:4, exp_rdata:32'hCAFE_F00D, exp_wr:4'b0000, exp_rdv:4'b0100};
    tv[5] = '{we:1'b1, addr:32'hBFD0_03FC, wdata:32'h0BAD_BEEF, sdata:32'h0,
              exp_err:1'b0, exp_lat:4, exp_rdata:32'hCAFE_F00D, exp_wr:4'b1000, exp_rdv:4'b0000};
    tv[6] = '{we:1'b0, addr:32'hBFD1_0300, wdata:32'h0, sdata:32'h0,
              exp_err:1'b1, exp_lat:1, exp_rdata:32'h0, exp_wr:4'b0000, exp_rdv:4'b0000};
    tv[7] = '{we:1'b0, addr:32'hBFD0_0F00, wdata:32'h0, sdata:32'h0,
              exp_err:1'b1, exp_lat:1, exp_rdata:32'h0, exp_wr:4'b0000, exp_rdv:4'b0000};
    tv[8] = '{we:1'b0, addr:32'hBFD0_0344, wdata:32'h0, sdata:32'h8765_4321,
              exp_err:1'b0, exp_lat:4, exp_rdata:32'h8765_4321, exp_wr:4'b0000, exp_rdv:4'b1000};
    tv[9] = '{we:1'b1, addr:32'hBFD0_0100, wdata:32'hFFFF_FFFF, sdata:32'h0,
              exp_err:1'b0, exp_lat:4, exp_rdata:32'h8765_4321, exp_wr:4'b0010, exp_rdv:4'b0000};

    rst = 1'b1;
    bif1.cpu_req = 1'b0; bif1.cpu_we = 1'b0; bif1.cpu_addr = 32'd0; bif1.cpu_wdata = 32'd0;
    bif0.cpu_req = 1'b0; bif0.cpu_we = 1'b0; bif0.cpu_addr = 32'd0; bif0.cpu_wdata = 32'd0;
    bif3.cpu_req = 1'b0; bif3.cpu_we = 1'b0; bif3.cpu_addr = 32'd0; bif3.cpu_wdata = 32'd0;
    bif1.bus_data_i = 128'd0; bif0.bus_data_i = 128'd0; bif3.bus_data_i = 128'd0;
    model_rd = 32'd0;

    repeat (3) @(posedge clk_bus);
    @(negedge clk_bus);
    chk("reset.cpu_ack", 32'(bif1.cpu_ack), 32'd0);
    chk("reset.cpu_err", 32'(bif1.cpu_err), 32'd0);
    chk("reset.cpu_rdata", bif1.cpu_rdata, 32'd0);
    chk("reset.bus_address", 32'(bif1.bus_address), 32'd0);
    chk("reset.bus_data_o", bif1.bus_data_o, 32'd0);
    chk("reset.bus_read", 32'(bif1.bus_read), 32'd0);
    chk("reset.bus_write", 32'(bif1.bus_write), 32'd0);
    @(posedge clk_bus); #1;
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        sbus[32*k +: 32] = $urandom;
        if (tv[i].addr[31:12] == 20'hBFD00 && tv[i].addr[11:8] == 4'(k))
          sbus[32*k +: 32] = tv[i].sdata;
      end
      run1($sformatf("vec%0d", i), tv[i].we, tv[i].addr, tv[i].wdata, sbus,
           tv[i].exp_err, tv[i].exp_lat, tv[i].exp_rdata, tv[i].exp_wr, tv[i].exp_rdv);
    end

    // Randomized accesses against the reference rules.
    for (int i = 0; i < 120; i++) begin
      we = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind < 7)
        addr = {20'hBFD00, 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'b00};
      else if (kind < 9)
        addr = {20'hBFD00, 4'($urandom_range(4, 15)), 6'($urandom_range(0, 63)), 2'b00};
      else
        addr = $urandom & 32'hFFFF_FFFC;
      wdata = $urandom;
      sbus = {$urandom, $urandom, $urandom, $urandom};
      slot = int'(addr[11:8]);
      exp_wr = 4'd0;
      exp_rdv = 4'd0;
      if (!ref_hit(addr)) begin
        exp_rd = 32'd0;
      end else if (we) begin
        exp_rd = model_rd;
        exp_wr = 4'b0001 << slot;
      end else begin
        exp_rd = sbus[32*slot +: 32];
        exp_rdv = 4'b0001 << slot;
      end
      run1($sformatf("rand%0d", i), we, addr, wdata, sbus, !ref_hit(addr),
           ref_hit(addr) ? 4 : 1, exp_rd, exp_wr, exp_rdv);
    end

    // Reset during the setup cycle of a write to the timer slot.
    @(posedge clk_bus); #1;
    bif1.bus_data_i = {$urandom, $urandom, $urandom, $urandom};
    bif1.cpu_req = 1'b1; bif1.cpu_we = 1'b1;
    bif1.cpu_addr = {20'hBFD00, SLOT_TIMER, 8'h08}; bif1.cpu_wdata = 32'hDEAD_BEEF;
    @(posedge clk_bus); #1;
    rst = 1'b1;
    @(negedge clk_bus);
    chk("rstsetup.no_strobe_in_setup", 32'(bif1.bus_write), 32'd0);
    @(posedge clk_bus); #1;
    rst = 1'b0;
    bif1.cpu_req = 1'b0;
    @(negedge clk_bus);
    chk("rstsetup.cpu_ack", 32'(bif1.cpu_ack), 32'd0);
    chk("rstsetup.cpu_err", 32'(bif1.cpu_err), 32'd0);
    chk("rstsetup.cpu_rdata", bif1.cpu_rdata, 32'd0);
    chk("rstsetup.bus_address", 32'(bif1.bus_address), 32'd0);
    chk("rstsetup.bus_data_o", bif1.bus_data_o, 32'd0);
    chk("rstsetup.bus_read", 32'(bif1.bus_read), 32'd0);
    chk("rstsetup.bus_write", 32'(bif1.bus_write), 32'd0);
    wr_seen = 1'b0; ack_seen = 1'b0;
    repeat (6) begin
      @(negedge clk_bus);
      if (bif1.bus_write != 4'd0) wr_seen = 1'b1;
      if (bif1.cpu_ack) ack_seen = 1'b1;
    end
    chk("rstsetup.no_write_pulse", 32'(wr_seen), 32'd0);
    chk("rstsetup.no_ack", 32'(ack_seen), 32'd0);
    model_rd = 32'd0;

    // Three back-to-back reads with req held high, RECOVERY=0.
    bif0.bus_data_i = {$urandom, 32'h0BB0_2222, $urandom, $urandom};
    @(posedge clk_bus); #1;
    bif0.cpu_req = 1'b1; bif0.cpu_we = 1'b0;
    bif0.cpu_addr = {20'hBFD00, SLOT_TIMER, 8'h10}; bif0.cpu_wdata = 32'd0;
    cyc = 0; nstb = 0; nack = 0; rd_seen = 32'd0;
    s_cyc = '{0, 0, 0}; a_cyc = '{0, 0, 0};
    while (nack < 3 && cyc < 60) begin
      @(negedge clk_bus);
      cyc++;
      if (bif0.bus_read != 4'd0 || bif0.bus_write != 4'd0) begin
        if (nstb < 3) s_cyc[nstb] = cyc;
        chk("b2b.strobe_pattern", 32'({bif0.bus_write, bif0.bus_read}), 32'h04);
        nstb++;
      end
      if (bif0.cpu_ack) begin
        if (nack < 3) a_cyc[nack] = cyc;
        rd_seen = bif0.cpu_rdata;
        nack++;
      end
    end
    @(posedge clk_bus); #1;
    bif0.cpu_req = 1'b0;
    repeat (8) begin
      @(negedge clk_bus);
      if (bif0.bus_read != 4'd0 || bif0.bus_write != 4'd0) nstb++;
      if (bif0.cpu_ack) nack++;
    end
    chk("b2b.ack_count", 32'(nack), 32'd3);
    chk("b2b.strobe_count", 32'(nstb), 32'd3);
    chk("b2b.first_latency", 32'(a_cyc[0] - 1), 32'd3);
    chk("b2b.strobe_gap1", 32'(s_cyc[1] - s_cyc[0]), 32'd4);
    chk("b2b.strobe_gap2", 32'(s_cyc[2] - s_cyc[1]), 32'd4);
    chk("b2b.ack_gap", 32'(a_cyc[1] - a_cyc[0]), 32'd4);
    chk("b2b.rdata", rd_seen, 32'h0BB0_2222);

    // Single write with RECOVERY=3.
    bif3.bus_data_i = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk_bus); #1;
    bif3.cpu_req = 1'b1; bif3.cpu_we = 1'b1;
    bif3.cpu_addr = {20'hBFD00, SLOT_GPIO, 8'h04}; bif3.cpu_wdata = 32'h5A5A_0003;
    cyc = 0; nstb = 0; nack = 0; exp_wr = 4'd0;
    while (nack == 0 && cyc < 40) begin
      @(negedge clk_bus);
      cyc++;
      if (bif3.bus_write != 4'd0 || bif3.bus_read != 4'd0) begin
        nstb++;
        exp_wr = bif3.bus_write;
      end
      if (bif3.cpu_ack) begin
        nack++;
        a_cyc[0] = cyc;
        ack_seen = bif3.cpu_err;
      end
    end
    @(posedge clk_bus); #1;
    bif3.cpu_req = 1'b0;
    chk("rec3.ack_seen", 32'(nack), 32'd1);
    chk("rec3.latency", 32'(a_cyc[0] - 1), 32'd6);
    chk("rec3.strobe_cycles", 32'(nstb), 32'd1);
    chk("rec3.bus_write", 32'(exp_wr), 32'h1);
    chk("rec3.err", 32'(ack_seen), 32'd0);

    // Remaining slot IDs used as an extra decode boundary on dut1.
    sbus = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    run1("slot_spare_read", 1'b0, {20'hBFD00, SLOT_SPARE, 8'h00}, 32'd0, sbus,
         1'b0, 4, 32'h3333_3333, 4'b0000, 4'b1000);
    run1("slot_uart_read", 1'b0, {20'hBFD00, SLOT_UART, 8'h0C}, 32'd0, sbus,
         1'b0, 4, 32'h1111_1111, 4'b0000, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
